wb_pwm_bank: RTL and testbench

Parametrised Wishbone PWM peripheral: NCH independent edge-aligned PWM channels with CW-bit counters, per-channel polarity, double-buffered (glitch-free) period/duty updates and a wrap interrupt. It sits on the LM32 Wishbone data bus as a slave and drives motor/servo PWM pins directly. Next generation of the fixed 8-channel, 8-bit PWM slave, replacing its internal byte-wide engine.

---
 rtl/wb_pwm_bank_pkg.sv | 21 ++
 rtl/pwm_bank_channel.sv | 77 +++++++
 rtl/wb_pwm_bank.sv | 94 +++++++++
 tb/tb_wb_pwm_bank.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pwm_bank_pkg.sv
// Shared register map and field positions for the Wishbone PWM bank.
// Imported by the top-level decoder and by every channel instance.
package wb_pwm_bank_pkg;

    typedef enum logic [1:0] {
        REG_CTRL   = 2'd0,
        REG_PERIOD = 2'd1,
        REG_DUTY   = 2'd2,
        REG_STATUS = 2'd3
    } reg_sel_e;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_POL    = 1;
    localparam int CTRL_IRQ_EN = 2;

    localparam int CH_STRIDE = 16;
    localparam int CH_LSB    = $clog2(CH_STRIDE);
    localparam int MAX_NCH   = 16;
    localparam int CH_W      = $clog2(MAX_NCH);

endpackage

// File: rtl/pwm_bank_channel.sv
// One edge-aligned PWM channel: control bits, pending/active period and duty,
// free-running counter, registered output and sticky wrap flag.
module pwm_bank_channel
    import wb_pwm_bank_pkg::*;
#(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_ctrl,
    input  logic          wr_period,
    input  logic          wr_duty,
    input  logic          wr_status,
    input  logic [31:0]   wdata,
    output logic [2:0]    ctrl,
    output logic [CW-1:0] period,
    output logic [CW-1:0] duty,
    output logic          flag,
    output logic          pwm,
    output logic          irq
);

    logic          en;
    logic          pol;
    logic          irq_en;
    logic [CW-1:0] period_act;
    logic [CW-1:0] duty_act;
    logic [CW-1:0] cnt;
    logic          wrap;
    logic          unused_wdata;

    assign unused_wdata = ^wdata;
    assign wrap         = en && (cnt == period_act);
    assign ctrl         = {irq_en, pol, en};
    assign irq          = flag & irq_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            en     <= 1'b0;
            pol    <= 1'b0;
            irq_en <= 1'b0;
            period <= '0;
            duty   <= '0;
        end else begin
            if (wr_ctrl) begin
                en     <= wdata[CTRL_EN];
                pol    <= wdata[CTRL_POL];
                irq_en <= wdata[CTRL_IRQ_EN];
            end
            if (wr_period) period <= wdata[CW-1:0];
            if (wr_duty)   duty   <= wdata[CW-1:0];
        end
    end

    // Active copies only move at a period boundary (or while idle), so a
    // running waveform never sees a half-updated period/duty pair.
    always_ff @(posedge clk) begin
        if (reset) begin
            period_act <= '0;
            duty_act   <= '0;
            cnt        <= '0;
            pwm        <= 1'b0;
            flag       <= 1'b0;
        end else begin
            if (!en || wrap) begin
                period_act <= period;
                duty_act   <= duty;
            end
            if (!en || wrap) cnt <= '0;
            else             cnt <= cnt + {{(CW-1){1'b0}}, 1'b1};
            pwm <= en ? ((cnt < duty_act) ^ pol) : pol;
            if (wrap)                       flag <= 1'b1;
            else if (wr_status && wdata[0]) flag <= 1'b0;
        end
    end

endmodule

// File: rtl/wb_pwm_bank.sv
// Wishbone classic slave fronting NCH PWM channels: address decode,
// single-cycle registered ack, registered read mux and interrupt OR.
module wb_pwm_bank
    import wb_pwm_bank_pkg::*;
#(
    parameter int NCH = 8,
    parameter int CW  = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           wb_stb_i,
    input  logic           wb_cyc_i,
    input  logic           wb_we_i,
    input  logic [31:0]    wb_adr_i,
    input  logic [3:0]     wb_sel_i,
    input  logic [31:0]    wb_dat_i,
    output logic [31:0]    wb_dat_o,
    output logic           wb_ack_o,
    output logic [NCH-1:0] pwm_o,
    output logic           irq_o
);

    logic            ack;
    logic            req;
    logic            wr;
    logic [CH_W-1:0] ch_sel;
    reg_sel_e        reg_sel;
    logic [31:0]     rdata;
    logic            unused_bus;

    logic [2:0]      ctrl   [NCH];
    logic [CW-1:0]   period [NCH];
    logic [CW-1:0]   duty   [NCH];
    logic [NCH-1:0]  flag;
    logic [NCH-1:0]  irq;

    // The ack register doubles as a one-cycle busy, so a held strobe
    // cannot start a second access until ack has dropped.
    assign req        = wb_stb_i & wb_cyc_i & ~ack;
    assign wr         = req & wb_we_i;
    assign ch_sel     = wb_adr_i[CH_LSB +: CH_W];
    assign reg_sel    = reg_sel_e'(wb_adr_i[3:2]);
    assign wb_ack_o   = ack & wb_stb_i & wb_cyc_i;
    assign irq_o      = |irq;
    assign unused_bus = ^{wb_sel_i, wb_adr_i[31:CH_LSB+CH_W], wb_adr_i[1:0]};

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic hit;
        assign hit = wr && (ch_sel == CH_W'(i));

        pwm_bank_channel #(.CW(CW)) u_ch (
            .clk       (clk),
            .reset     (reset),
            .wr_ctrl   (hit && (reg_sel == REG_CTRL)),
            .wr_period (hit && (reg_sel == REG_PERIOD)),
            .wr_duty   (hit && (reg_sel == REG_DUTY)),
            .wr_status (hit && (reg_sel == REG_STATUS)),
            .wdata     (wb_dat_i),
            .ctrl      (ctrl[i]),
            .period    (period[i]),
            .duty      (duty[i]),
            .flag      (flag[i]),
            .pwm       (pwm_o[i]),
            .irq       (irq[i])
        );
    end

    // Channels beyond NCH never match, so their reads fall through to zero.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < NCH; i++) begin
            if (ch_sel == CH_W'(i)) begin
                case (reg_sel)
                    REG_CTRL:   rdata = {29'd0, ctrl[i]};
                    REG_PERIOD: rdata = 32'(period[i]);
                    REG_DUTY:   rdata = 32'(duty[i]);
                    REG_STATUS: rdata = {31'd0, flag[i]};
                    default:    rdata = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ack      <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            ack <= req;
            if (req && !wb_we_i) wb_dat_o <= rdata;
        end
    end

endmodule

// File: tb/tb_wb_pwm_bank.sv
// Randomized and directed bench for wb_pwm_bank against a cycle-level
// behavioural model of the register map and waveform rules.
module tb_wb_pwm_bank;

    localparam int NCH   = 8;
    localparam int CW    = 16;
    localparam int NCH_S = 2;
    localparam int CW_S  = 8;
    localparam longint MASK = (longint'(1) << CW) - 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic stb0 = 1'b0, stb1 = 1'b0, we = 1'b0;
    logic [31:0] adr = '0, wdat = '0;
    logic [3:0]  sel = 4'hF;
    logic [31:0] dat0, dat1;
    logic        ack0, ack1, irq0, irq1;
    logic [NCH-1:0]   pwm0;
    logic [NCH_S-1:0] pwm1;

    always #5 clk = ~clk;

    wb_pwm_bank #(.NCH(NCH), .CW(CW)) dut (
        .clk(clk), .reset(reset), .wb_stb_i(stb0), .wb_cyc_i(stb0), .wb_we_i(we),
        .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(wdat), .wb_dat_o(dat0),
        .wb_ack_o(ack0), .pwm_o(pwm0), .irq_o(irq0));

    wb_pwm_bank #(.NCH(NCH_S), .CW(CW_S)) dut_s (
        .clk(clk), .reset(reset), .wb_stb_i(stb1), .wb_cyc_i(stb1), .wb_we_i(we),
        .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(wdat), .wb_dat_o(dat1),
        .wb_ack_o(ack1), .pwm_o(pwm1), .irq_o(irq1));

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state for the main DUT (one entry per channel).
    bit     m_en[NCH], m_pol[NCH], m_ie[NCH], m_flag[NCH], m_pwm[NCH];
    longint m_pp[NCH], m_pd[NCH], m_pa[NCH], m_da[NCH], m_cnt[NCH];
    bit     m_ack;
    longint m_rd;

    task automatic model_step();
        bit req, wr;
        int ch, r;
        if (reset) begin
            for (int c = 0; c < NCH; c++) begin
                m_en[c] = 0; m_pol[c] = 0; m_ie[c] = 0; m_flag[c] = 0; m_pwm[c] = 0;
                m_pp[c] = 0; m_pd[c] = 0; m_pa[c] = 0; m_da[c] = 0; m_cnt[c] = 0;
            end
            m_ack = 0;
            m_rd  = 0;
            return;
        end
        req = stb0 && !m_ack;
        wr  = req && we;
        ch  = int'(adr[7:4]);
        r   = int'(adr[3:2]);
        if (req && !we) begin
            m_rd = 0;
            if (ch < NCH) begin
                case (r)
                    0: m_rd = longint'(m_en[ch]) + 2 * longint'(m_pol[ch]) + 4 * longint'(m_ie[ch]);
                    1: m_rd = m_pp[ch];
                    2: m_rd = m_pd[ch];
                    default: m_rd = longint'(m_flag[ch]);
                endcase
            end
        end
        for (int c = 0; c < NCH; c++) begin
            bit     at_end;
            longint nxt;
            at_end   = m_en[c] && (m_cnt[c] == m_pa[c]);
            m_pwm[c] = m_en[c] ? ((m_cnt[c] < m_da[c]) ^ m_pol[c]) : m_pol[c];
            nxt      = m_en[c] ? (m_cnt[c] + 1) % (m_pa[c] + 1) : 0;
            if (at_end) m_flag[c] = 1;
            else if (wr && ch == c && r == 3 && wdat[0]) m_flag[c] = 0;
            if (!m_en[c] || at_end) begin
                m_pa[c] = m_pp[c];
                m_da[c] = m_pd[c];
            end
            m_cnt[c] = nxt;
            if (wr && ch == c) begin
                case (r)
                    0: begin m_en[c] = wdat[0]; m_pol[c] = wdat[1]; m_ie[c] = wdat[2]; end
                    1: m_pp[c] = longint'(wdat) & MASK;
                    2: m_pd[c] = longint'(wdat) & MASK;
                    default: ;
                endcase
            end
        end
        m_ack = req;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    bit chk_on = 0;

    initial forever begin
        logic [NCH-1:0] ep;
        bit ei;
        @(negedge clk);
        if (chk_on) begin
            ei = 0;
            for (int c = 0; c < NCH; c++) begin
                ep[c] = m_pwm[c];
                ei    = ei | (m_flag[c] & m_ie[c]);
            end
            check("pwm_o", longint'(pwm0), longint'(ep));
            check("irq_o", longint'(irq0), longint'(ei));
            check("ack_o", longint'(ack0), longint'(m_ack && stb0));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic xfer(input int unit, input bit w, input int ch, input int r,
                        input longint d, output longint rd);
        int n;
        bit got;
        adr  = 32'(ch * 16 + r * 4);
        wdat = 32'(d);
        we   = w;
        if (unit == 0) stb0 = 1'b1; else stb1 = 1'b1;
        n   = 0;
        got = 0;
        while (!got && n < 8) begin
            @(negedge clk);
            n++;
            got = (unit == 0) ? ack0 : ack1;
        end
        check("ack_seen", longint'(got), 1);
        rd = (unit == 0) ? longint'(dat0) : longint'(dat1);
        @(posedge clk);
        #1;
        stb0 = 1'b0;
        stb1 = 1'b0;
        we   = 1'b0;
    endtask

    task automatic wr0(input int ch, input int r, input longint d);
        longint rd;
        xfer(0, 1, ch, r, d, rd);
    endtask

    task automatic rd0(input int ch, input int r);
        longint rd;
        xfer(0, 0, ch, r, 0, rd);
        check("read", rd, m_rd);
    endtask

    function automatic bit sig(input int unit, input int ch);
        return (unit == 0) ? pwm0[ch] : pwm1[ch];
    endfunction

    // Finds a rising edge, then counts cycles and high cycles up to the next one.
    task automatic measure(input int unit, input int ch, output int hi, output int per);
        bit prev, cur, rise;
        int n;
        hi = 0; per = 0; n = 0; rise = 0;
        prev = sig(unit, ch);
        while (!rise && n < 700) begin
            @(negedge clk);
            n++;
            cur  = sig(unit, ch);
            rise = cur && !prev;
            prev = cur;
        end
        if (!rise) begin
            check("rise_timeout", 0, 1);
            return;
        end
        hi = 1; per = 1; n = 0; rise = 0;
        while (n < 700) begin
            @(negedge clk);
            n++;
            cur = sig(unit, ch);
            if (cur && !prev) break;
            per++;
            hi  += int'(cur);
            prev = cur;
        end
        if (n >= 700) check("period_timeout", 0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        longint rd;
        int hi, per;

        tick(3);
        chk_on = 1;
        reset  = 1'b0;
        check("dat_after_reset", longint'(dat0), 0);
        check("pwm_after_reset", longint'(pwm0), 0);
        for (int c = 0; c < NCH; c++)
            for (int r = 0; r < 4; r++) rd0(c, r);

        // Out-of-range read with the strobe held: one ack, then a blocked cycle.
        adr = 32'(9 * 16); we = 1'b0; stb0 = 1'b1;
        @(negedge clk); check("oor_ack_pre", longint'(ack0), 0);
        @(negedge clk); check("oor_ack", longint'(ack0), 1);
        check("oor_data", longint'(dat0), 0);
        @(negedge clk); check("oor_ack_gap", longint'(ack0), 0);
        @(posedge clk); #1; stb0 = 1'b0;
        tick(2);

        wr0(0, 1, 9); wr0(0, 2, 3); wr0(0, 0, 1);
        measure(0, 0, hi, per);
        check("basic_hi", hi, 3);
        check("basic_per", per, 10);
        tick(1);
        wr0(0, 2, 5);
        measure(0, 0, hi, per);
        check("shadow_hi", hi, 5);
        check("shadow_per", per, 10);
        tick(1);

        wr0(0, 2, 0);  tick(25); check("duty_zero", longint'(pwm0[0]), 0);
        wr0(0, 2, 12); tick(25); check("duty_over", longint'(pwm0[0]), 1);
        wr0(0, 2, 3);  wr0(0, 0, 3);
        measure(0, 0, hi, per);
        check("pol_hi", hi, 7);
        check("pol_per", per, 10);
        tick(1);
        wr0(0, 0, 2); tick(3); check("disabled_pol", longint'(pwm0[0]), 1);

        wr0(1, 1, 40); wr0(1, 0, 5);
        tick(45);
        rd0(1, 3);
        check("irq_set", longint'(irq0), 1);
        wr0(1, 3, 1);
        check("irq_clr", longint'(irq0), 0);
        rd0(1, 3);
        wr0(1, 1, 4);
        tick(50);
        for (int k = 0; k < 10; k++) begin
            wr0(1, 3, 1);
            tick(1);
        end

        wr0(2, 1, 6); wr0(2, 2, 2); wr0(2, 0, 3);
        tick(9);
        reset = 1'b1; tick(1); reset = 1'b0;
        check("reset_mid_pwm", longint'(pwm0), 0);
        check("reset_mid_irq", longint'(irq0), 0);
        tick(2);

        for (int t = 0; t < 80; t++) begin
            int ch, r;
            bit w;
            longint v;
            ch = $urandom_range(0, 9);
            r  = $urandom_range(0, 3);
            w  = ($urandom_range(0, 3) != 0);
            case (r)
                0:       v = $urandom_range(0, 7) | ($urandom_range(0, 3) != 0 ? 1 : 0);
                1:       v = $urandom_range(0, 12) | (longint'($urandom_range(0, 1)) << 20);
                2:       v = $urandom_range(0, 14);
                default: v = $urandom_range(0, 1);
            endcase
            if (w) wr0(ch, r, v);
            else   rd0(ch, r);
            tick($urandom_range(0, 15));
        end

        xfer(1, 1, 0, 1, 'h1FF, rd);
        xfer(1, 0, 0, 1, 0, rd);
        check("cw8_trunc", rd, 'hFF);
        xfer(1, 1, 0, 2, 1, rd);
        xfer(1, 1, 0, 0, 1, rd);
        measure(1, 0, hi, per);
        check("cw8_per", per, 256);
        check("cw8_hi", hi, 1);
        tick(1);
        xfer(1, 1, 2, 0, 1, rd);
        xfer(1, 0, 2, 0, 0, rd);
        check("nch2_ch2_read", rd, 0);
        xfer(1, 0, 0, 0, 0, rd);
        check("nch2_ch0_ctrl", rd, 1);
        xfer(1, 0, 1, 0, 0, rd);
        check("nch2_ch1_ctrl", rd, 0);
        check("nch2_pwm1", longint'(pwm1[1]), 0);
        tick(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
